// File: rtl/sd_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_spi_pkg
// Description : Shared constants and types for the SPI-mode SD-card responder.
//               Holds command indices, R1/token/OCR values and the FSM enum.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_spi_pkg;

    // Command indices
    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD16  = 6'd16;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] CMD58  = 6'd58;

    // Response / token bytes
    localparam logic [7:0]  R1_READY    = 8'h00;
    localparam logic [7:0]  R1_IDLE     = 8'h01;
    localparam logic [7:0]  R1_ILLEGAL  = 8'h04;
    localparam logic [7:0]  TOKEN_START = 8'hFE;
    localparam logic [7:0]  IDLE_BYTE   = 8'hFF;
    localparam logic [31:0] OCR_SDHC    = 32'hC0FF8000;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_CMD   = 3'd1,
        NCR      = 3'd2,
        RESP     = 3'd3,
        RD_WAIT  = 3'd4,
        RD_TOKEN = 3'd5,
        RD_DATA  = 3'd6,
        RD_CRC   = 3'd7
    } fsm_state_t;

    // R1 for a rejected command: illegal-command bit plus current idle flag
    function automatic logic [7:0] r1_illegal(input logic idle);
        return R1_ILLEGAL | {7'b0, idle};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_sync
// Description : Brings the asynchronous SPI pins into the clk domain with
//               two-flop synchronizers and detects SCLK edges.
// Ports       : clk, rst           - system clock, async active-high reset
//               sclk, cs, mosi     - raw SPI pins
//               sclk_rise/fall     - one-cycle pulses on synchronized edges
//               cs_n_s, mosi_s     - synchronized chip select / data
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_sync (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_n_s,
    output logic mosi_s
);

    // Third SCLK stage gives the previous synchronized value for edge detect
    logic [2:0] r_sclk;
    logic [1:0] r_cs;
    logic [1:0] r_mosi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk <= 3'b000;
            r_cs   <= 2'b11;
            r_mosi <= 2'b11;
        end else begin
            r_sclk <= {r_sclk[1:0], sclk};
            r_cs   <= {r_cs[0], cs};
            r_mosi <= {r_mosi[0], mosi};
        end
    end

    assign sclk_rise = r_sclk[1] & ~r_sclk[2];
    assign sclk_fall = ~r_sclk[1] & r_sclk[2];
    assign cs_n_s    = r_cs[1];
    assign mosi_s    = r_mosi[1];

endmodule
`default_nettype wire

// File: rtl/sd_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : sd_spi_responder
// Description : SPI-mode SD-card emulator. Decodes 6-byte command frames,
//               answers with R1/R3/R7 and serves 512-byte single-block reads
//               from an external byte memory (1-cycle read latency).
// Ports       : clk, rst               - system clock, async active-high reset
//               sclk, cs, mosi, miso   - SPI mode 0 slave pins (cs active low)
//               mem_addr, mem_rd       - {block, byte} read address + strobe
//               mem_data               - read data, valid 1 clk after mem_rd
//               card_ready             - set once ACMD41 reports ready
//               last_cmd               - index of last decoded command
// Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int N_IDLE_POLLS  = 2,
    parameter int NCR_BYTES     = 1,
    parameter int RD_WAIT_BYTES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic [40:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic        card_ready,
    output logic [5:0]  last_cmd
);

    localparam logic [7:0] c_poll_limit = 8'(N_IDLE_POLLS);
    localparam logic [9:0] c_ncr_bytes  = 10'(NCR_BYTES);
    localparam logic [9:0] c_wait_bytes = 10'(RD_WAIT_BYTES);
    localparam logic [9:0] c_last_data  = 10'd511;

    logic w_sclk_rise, w_sclk_fall, w_cs_n_s, w_mosi_s;

    spi_slave_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .sclk_rise (w_sclk_rise),
        .sclk_fall (w_sclk_fall),
        .cs_n_s    (w_cs_n_s),
        .mosi_s    (w_mosi_s)
    );

    fsm_state_t  r_state;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_rx_sr;
    logic [7:0]  r_tx_sr;
    logic [9:0]  r_cnt;          // per-state byte counter
    logic [5:0]  r_cmd;
    logic [31:0] r_arg;
    logic [39:0] r_resp;         // response bytes, next one in [39:32]
    logic [2:0]  r_resp_len;
    logic        r_rd_go;
    logic        r_idle;
    logic        r_app;
    logic [7:0]  r_poll;
    logic        r_fetch_pend;
    logic [9:0]  r_fetch_idx;    // bit 9 set once all 512 bytes are fetched
    logic        r_rd_q;
    logic [7:0]  r_data_buf;

    logic [7:0]  w_rx_byte;
    logic [7:0]  w_r1;
    logic [39:0] w_resp;
    logic [2:0]  w_resp_len;
    logic        w_rd_go;
    logic        w_idle_nx;
    logic        w_app_nx;
    logic [7:0]  w_poll_nx;
    logic        w_ready_nx;

    assign w_rx_byte = {r_rx_sr, w_mosi_s};
    assign w_r1      = {7'b0, r_idle};

    // Command decode, evaluated when the CRC byte completes the frame
    always_comb begin
        w_resp     = {r1_illegal(r_idle), 32'hFFFF_FFFF};
        w_resp_len = 3'd1;
        w_rd_go    = 1'b0;
        w_idle_nx  = r_idle;
        w_app_nx   = 1'b0;
        w_poll_nx  = r_poll;
        w_ready_nx = card_ready;
        if (r_app && (r_cmd == ACMD41)) begin
            if (r_poll != 8'hFF) begin
                w_poll_nx = r_poll + 8'd1;
            end
            if (r_poll < c_poll_limit) begin
                w_resp[39:32] = R1_IDLE;
            end else begin
                w_resp[39:32] = R1_READY;
                w_idle_nx     = 1'b0;
                w_ready_nx    = 1'b1;
            end
        end else if (!r_app) begin
            case (r_cmd)
                CMD0: begin
                    w_resp[39:32] = R1_IDLE;
                    w_idle_nx     = 1'b1;
                    w_ready_nx    = 1'b0;
                end
                CMD8: begin
                    w_resp     = {w_r1, 8'h00, 8'h00, {4'h0, r_arg[11:8]}, r_arg[7:0]};
                    w_resp_len = 3'd5;
                end
                CMD55: begin
                    w_resp[39:32] = w_r1;
                    w_app_nx      = 1'b1;
                end
                CMD58: begin
                    w_resp     = {w_r1, OCR_SDHC};
                    w_resp_len = 3'd5;
                end
                CMD16: begin
                    w_resp[39:32] = w_r1;
                end
                CMD17: begin
                    if (r_idle) begin
                        w_resp[39:32] = R1_ILLEGAL | R1_IDLE;
                    end else begin
                        w_resp[39:32] = R1_READY;
                        w_rd_go       = 1'b1;
                    end
                end
                default: begin
                    w_resp[39:32] = r1_illegal(r_idle);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso         <= 1'b1;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            card_ready   <= 1'b0;
            last_cmd     <= '0;
            r_state      <= RX_IDLE;
            r_bit_cnt    <= '0;
            r_rx_sr      <= '0;
            r_tx_sr      <= IDLE_BYTE;
            r_cnt        <= '0;
            r_cmd        <= '0;
            r_arg        <= '0;
            r_resp       <= '1;
            r_resp_len   <= 3'd1;
            r_rd_go      <= 1'b0;
            r_idle       <= 1'b1;
            r_app        <= 1'b0;
            r_poll       <= '0;
            r_fetch_pend <= 1'b0;
            r_fetch_idx  <= '0;
            r_rd_q       <= 1'b0;
            r_data_buf   <= 8'hFF;
        end else begin
            mem_rd <= 1'b0;
            r_rd_q <= mem_rd;
            if (r_rd_q) begin
                r_data_buf <= mem_data;
            end

            // One prefetch per loaded data byte, issued the cycle after the load
            if (r_fetch_pend) begin
                r_fetch_pend <= 1'b0;
                if (!r_fetch_idx[9]) begin
                    mem_rd      <= 1'b1;
                    mem_addr    <= {r_arg, r_fetch_idx[8:0]};
                    r_fetch_idx <= r_fetch_idx + 10'd1;
                end
            end

            if (w_cs_n_s) begin
                miso         <= 1'b1;
                r_tx_sr      <= IDLE_BYTE;
                r_bit_cnt    <= '0;
                r_state      <= RX_IDLE;
                r_fetch_pend <= 1'b0;
            end else begin
                if (w_sclk_fall) begin
                    miso    <= r_tx_sr[7];
                    r_tx_sr <= {r_tx_sr[6:0], 1'b1};
                end
                if (w_sclk_rise) begin
                    r_rx_sr   <= w_rx_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        // Byte boundary: consume RX byte, load the next TX byte
                        r_tx_sr <= IDLE_BYTE;
                        case (r_state)
                            RX_IDLE: begin
                                if (w_rx_byte[7:6] == 2'b01) begin
                                    r_cmd   <= w_rx_byte[5:0];
                                    r_cnt   <= '0;
                                    r_state <= RX_CMD;
                                end
                            end
                            RX_CMD: begin
                                if (r_cnt < 10'd4) begin
                                    r_arg <= {r_arg[23:0], w_rx_byte};
                                    r_cnt <= r_cnt + 10'd1;
                                end else begin
                                    r_resp     <= w_resp;
                                    r_resp_len <= w_resp_len;
                                    r_rd_go    <= w_rd_go;
                                    r_idle     <= w_idle_nx;
                                    r_app      <= w_app_nx;
                                    r_poll     <= w_poll_nx;
                                    card_ready <= w_ready_nx;
                                    last_cmd   <= r_cmd;
                                    r_cnt      <= 10'd1;
                                    r_state    <= NCR;
                                end
                            end
                            NCR: begin
                                if (r_cnt >= c_ncr_bytes) begin
                                    r_tx_sr <= r_resp[39:32];
                                    r_resp  <= {r_resp[31:0], 8'hFF};
                                    r_cnt   <= 10'd1;
                                    r_state <= RESP;
                                end else begin
                                    r_cnt <= r_cnt + 10'd1;
                                end
                            end
                            RESP: begin
                                if (r_cnt < {7'b0, r_resp_len}) begin
                                    r_tx_sr <= r_resp[39:32];
                                    r_resp  <= {r_resp[31:0], 8'hFF};
                                    r_cnt   <= r_cnt + 10'd1;
                                end else if (r_rd_go) begin
                                    r_cnt   <= 10'd1;
                                    r_state <= RD_WAIT;
                                end else begin
                                    r_state <= RX_IDLE;
                                end
                            end
                            RD_WAIT: begin
                                if (r_cnt >= c_wait_bytes) begin
                                    r_tx_sr      <= TOKEN_START;
                                    r_fetch_idx  <= '0;
                                    r_fetch_pend <= 1'b1;
                                    r_state      <= RD_TOKEN;
                                end else begin
                                    r_cnt <= r_cnt + 10'd1;
                                end
                            end
                            RD_TOKEN: begin
                                r_tx_sr      <= r_data_buf;
                                r_cnt        <= '0;
                                r_fetch_pend <= 1'b1;
                                r_state      <= RD_DATA;
                            end
                            RD_DATA: begin
                                if (r_cnt == c_last_data) begin
                                    r_cnt   <= '0;
                                    r_state <= RD_CRC;
                                end else begin
                                    r_tx_sr      <= r_data_buf;
                                    r_cnt        <= r_cnt + 10'd1;
                                    r_fetch_pend <= 1'b1;
                                end
                            end
                            RD_CRC: begin
                                if (r_cnt == 10'd0) begin
                                    r_cnt <= 10'd1;
                                end else begin
                                    r_state <= RX_IDLE;
                                end
                            end
                            default: begin
                                r_state <= RX_IDLE;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sd_spi_responder.md
# sd_spi_responder

Synthesizable SPI-mode SD-card emulator that answers the SPI master inside `nanofs_wrapper`. It lets the whole file-read path be exercised without a physical card, in simulation or on the Nexys4DDR with the SPI pins looped to this block. It decodes 6-byte SD command frames, returns R1/R3/R7 responses, and serves 512-byte single-block reads from an external byte memory.

## Interface
Parameters:
- `N_IDLE_POLLS`, default 2: number of ACMD41 commands answered 0x01 before 0x00 (ready) is returned.
- `NCR_BYTES`, default 1: 0xFF filler bytes sent between the command's last byte and the R1 byte (1..8).
- `RD_WAIT_BYTES`, default 2: 0xFF bytes sent between the CMD17 R1 and the 0xFE data token.

Ports:
- `clk`, in, 1: system clock. Must be at least 8× the SCLK frequency.
- `rst`, in, 1: asynchronous, active-high reset.
- `sclk`, in, 1: SPI clock from the master (asynchronous to `clk`).
- `cs`, in, 1: chip select, active low.
- `mosi`, in, 1: master-to-card data.
- `miso`, out, 1: card-to-master data.
- `mem_addr`, out, 41: read address, `{block[31:0], byte[8:0]}`.
- `mem_rd`, out, 1: one-cycle read strobe.
- `mem_data`, in, 8: read data, valid exactly 1 `clk` after `mem_rd`.
- `card_ready`, out, 1: high once ACMD41 has returned 0x00.
- `last_cmd`, out, 6: index of the last decoded command.

## Operation
SPI mode 0, MSB first:
- MOSI is sampled on each detected SCLK rising edge.
- MISO changes on each detected falling edge and shows `tx_sr[7]`.
- A bit counter counts rising edges. At the 8th edge the RX byte completes and the next TX byte loads into `tx_sr`.

Command frame:
- A frame starts with a received byte whose bits [7:6] are `01`. Bits [5:0] give the command index.
- The next 4 bytes are the argument, MSB first. The 6th byte (CRC) is ignored.
- Bytes that arrive while not in RX states are discarded.

FSM states and transitions:
- RX_IDLE → RX_CMD on a frame start byte.
- RX_CMD → NCR after 5 more bytes.
- NCR → RESP after `NCR_BYTES` × 0xFF.
- RESP → RX_IDLE, or RESP → RD_WAIT for an accepted CMD17.
- RD_WAIT → RD_TOKEN (0xFE) → RD_DATA (512 bytes) → RD_CRC (0xFF, 0xFF) → RX_IDLE.

Card-state flags:
- `idle` is 1 after reset and is set again by CMD0.
- `app` is set by CMD55 and cleared after the next command's response.

Responses, where R1 bit0 = `idle` and 0x04 = illegal:
- CMD0: R1 0x01.
- CMD8: R7 = R1, 0x00, 0x00, `{4'h0, arg[11:8]}`, `arg[7:0]`.
- CMD55: R1.
- ACMD41: an internal poll counter increments on each ACMD41. R1 is 0x01 while the counter < `N_IDLE_POLLS`. Otherwise `idle` clears and R1 is 0x00.
- CMD58: R3 = R1, 0xC0, 0xFF, 0x80, 0x00 (powered up, CCS=1).
- CMD16: R1.
- CMD17 with `idle`=0: R1 0x00, then the data path. The argument is a block address (SDHC).
- CMD17 with `idle`=1: R1 0x05, no data.
- Any other command, or a CMD other than 41 while `app`=1: R1 `{5'b0, 1'b1, 1'b0, idle}`.

Data path:
- For byte k (0..511), the block enters RD_DATA with `mem_rd` asserted and `mem_addr = {arg, k}`, one `clk` after the previous byte loads into `tx_sr`.
- The returned data is held until the next byte boundary.

## Timing
- SCLK, CS and MOSI pass through 2-FF synchronizers. Edge detection adds ≤3 `clk` of delay, so MISO changes ≤4 `clk` after a real SCLK falling edge.
- Reset values: `miso`=1, `mem_rd`=0, `mem_addr`=0, `card_ready`=0, `last_cmd`=0. Internally: `idle`=1, `app`=0, poll counter=0, FSM=RX_IDLE.
- CS high (synchronized):
  - `miso` is held at 1.
  - The bit counter clears.
  - The FSM returns to RX_IDLE from any state, including mid-read; the block counter is abandoned.
  - Card flags are kept.
- After CS falls, the first TX byte is 0xFF.
- Whenever the FSM has nothing to send, it transmits 0xFF.
- At most one `mem_rd` is issued per SPI byte.
- RESP bytes are sent on consecutive byte slots with no gaps.

## Structure
- Shared package `sd_spi_pkg`:
  - command index constants (CMD0/8/16/17/55/58, ACMD41)
  - R1 bit constants, `TOKEN_START=8'hFE`, `OCR_SDHC=32'hC0FF8000`
  - the `fsm_state_t` enum
- Sub-module `spi_slave_sync`: synchronizers plus edge detection. Outputs `sclk_rise`, `sclk_fall`, `cs_n_s`, `mosi_s`.

## Test plan
- CMD0 with argument 0 → after 1 × 0xFF, MISO returns 0x01; `last_cmd`=0.
- CMD8 with argument 0x000001AA → response bytes 01 00 00 01 AA.
- CMD55+ACMD41 four times with `N_IDLE_POLLS`=2 → R1 sequence 01,01,00,00; `card_ready` rises after the 3rd ACMD41.
- CMD17 with argument 5 after init, memory returning byte = addr[7:0] → R1 00, FF FF, FE, then 00..FF,00..FF, then FF FF. `mem_addr[40:9]`=5 throughout.
- CMD17 before init → R1 05 with no token. CMD63 after init → R1 04.
- CS raised after 100 data bytes of a CMD17 → MISO=1. A following CMD0 is answered 0x01 correctly.
